// File: rtl/imem_loader.sv
// Streams a host program into instruction memory, optionally reads it back and
// compares checksums, then releases the CPU from reset.
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int CW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          verify_en,
    input  logic          s_valid,
    input  logic [31:0]   s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic          we_b,
    output logic [31:0]   addr_b,
    output logic [31:0]   din_b,
    input  logic [31:0]   dout_b,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] word_count
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE, S_ERR} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] wc_q, wc_d;
    logic          vfy_q, vfy_d;
    logic [31:0]   lsum_q, lsum_d;
    logic [31:0]   rsum_q, rsum_d;
    logic [CW:0]   vcnt_q, vcnt_d;
    logic          cap_q, cap_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wc_q    <= '0;
            vfy_q   <= 1'b0;
            lsum_q  <= '0;
            rsum_q  <= '0;
            vcnt_q  <= '0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wc_q    <= wc_d;
            vfy_q   <= vfy_d;
            lsum_q  <= lsum_d;
            rsum_q  <= rsum_d;
            vcnt_q  <= vcnt_d;
            cap_q   <= cap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wc_d      = wc_q;
        vfy_d     = vfy_q;
        lsum_d    = lsum_q;
        rsum_d    = rsum_q;
        vcnt_d    = vcnt_q;
        cap_d     = cap_q;
        s_ready   = 1'b0;
        we_b      = 1'b0;
        addr_b    = '0;
        din_b     = '0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_rst_n = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                cpu_rst_n = (state_q != S_ERR);
                done      = (state_q == S_DONE);
                error     = (state_q == S_ERR);
                if (start) begin
                    state_d = S_LOAD;
                    vfy_d   = verify_en;
                    idx_d   = '0;
                    wc_d    = '0;
                    lsum_d  = '0;
                    rsum_d  = '0;
                    vcnt_d  = '0;
                    cap_d   = 1'b0;
                end
            end
            S_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) begin
                    we_b   = 1'b1;
                    addr_b = 32'(idx_q) << 2;
                    din_b  = s_data;
                    idx_d  = idx_q + 1'b1;
                    wc_d   = wc_q + 1'b1;
                    lsum_d = lsum_q + s_data;
                    if (s_last)
                        state_d = vfy_q ? S_VERIFY : S_DONE;
                    else if (idx_q == IW'(DEPTH - 1))
                        state_d = S_ERR;
                end
            end
            S_VERIFY: begin
                busy   = 1'b1;
                vcnt_d = vcnt_q + 1'b1;
                cap_d  = 1'b0;
                if (vcnt_q < {1'b0, wc_q}) begin
                    addr_b = 32'(vcnt_q) << 2;
                    cap_d  = 1'b1;
                end
                // Memory returns data one cycle after the address, so capture lags by one.
                if (cap_q)
                    rsum_d = rsum_q + dout_b;
                if (vcnt_q == ({1'b0, wc_q} + 1'b1))
                    state_d = (rsum_q == lsum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (DEPTH=4) with a one-cycle-latency memory model.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, verify_en = 1'b0;
    logic        s_valid = 1'b0, s_last = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready, we_b, cpu_rst_n, busy, done, error;
    logic [31:0] addr_b, din_b, dout_b;
    logic [2:0]  word_count;

    int checks = 0, errors = 0;
    int wr_cnt = 0, wr_base;
    logic corrupt = 1'b0;
    logic [31:0] mem [4];

    localparam logic [31:0] W0 = 32'h0000_0013, W1 = 32'h0010_0093, W2 = 32'h0020_8113;

    imem_loader #(.DEPTH(4), .CW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .verify_en(verify_en),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we_b) begin
            mem[addr_b[3:2]] <= din_b;
            wr_cnt <= wr_cnt + 1;
        end
        dout_b <= (corrupt && addr_b[3:2] == 2'd1) ? mem[1] + 32'd1 : mem[addr_b[3:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // status = {s_ready, busy, done, error, cpu_rst_n}
    task automatic chk_st(input string tag, input logic [4:0] exp);
        chk(tag, 32'({s_ready, busy, done, error, cpu_rst_n}), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic ve);
        start = 1'b1;
        verify_en = ve;
        tick();
        start = 1'b0;
        verify_en = 1'b0;
    endtask

    task automatic send(input string tag, input logic [31:0] d, input logic last, input logic [31:0] exp_addr);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        #4;
        chk({tag, "_we"}, 32'(we_b), 32'd1);
        chk({tag, "_addr"}, addr_b, exp_addr);
        chk({tag, "_din"}, din_b, d);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic vstep(input string tag, input logic [31:0] exp_addr);
        #4;
        chk({tag, "_addr"}, addr_b, exp_addr);
        chk({tag, "_we"}, 32'(we_b), 32'd0);
        chk_st({tag, "_st"}, 5'b01000);
        tick();
    endtask

    initial begin
        // reset state
        #3;
        chk_st("rst_st", 5'b00001);
        chk("rst_we", 32'(we_b), 32'd0);
        chk("rst_addr", addr_b, 32'd0);
        chk("rst_din", din_b, 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        #9 rst = 1'b1;
        tick();

        // plain load, no verify
        do_start(1'b0);
        #4 chk_st("load_st", 5'b11000);
        #0 tick_back();
        send("t1w0", W0, 1'b0, 32'h0);
        send("t1w1", W1, 1'b0, 32'h4);
        send("t1w2", W2, 1'b1, 32'h8);
        #4;
        chk_st("t1_done", 5'b00101);
        chk("t1_wc", 32'(word_count), 32'd3);
        chk("t1_we", 32'(we_b), 32'd0);
        tick();

        // load with verify, good memory
        do_start(1'b1);
        send("t2w0", W0, 1'b0, 32'h0);
        send("t2w1", W1, 1'b0, 32'h4);
        send("t2w2", W2, 1'b1, 32'h8);
        vstep("t2v0", 32'h0);
        vstep("t2v1", 32'h4);
        vstep("t2v2", 32'h8);
        vstep("t2v3", 32'h0);
        vstep("t2v4", 32'h0);
        #4 chk_st("t2_done", 5'b00101);
        tick();

        // load with verify, word 1 corrupted on readback
        corrupt = 1'b1;
        do_start(1'b1);
        send("t3w0", W0, 1'b0, 32'h0);
        send("t3w1", W1, 1'b0, 32'h4);
        send("t3w2", W2, 1'b1, 32'h8);
        repeat (5) tick();
        #4 chk_st("t3_err", 5'b00010);
        tick();
        corrupt = 1'b0;

        // overflow: DEPTH words with no s_last
        do_start(1'b0);
        send("t4w0", 32'h11, 1'b0, 32'h0);
        send("t4w1", 32'h22, 1'b0, 32'h4);
        send("t4w2", 32'h33, 1'b0, 32'h8);
        send("t4w3", 32'h44, 1'b0, 32'hC);
        #4;
        chk_st("t4_err", 5'b00010);
        chk("t4_wc", 32'(word_count), 32'd4);
        tick();
        do_start(1'b0);
        #4;
        chk_st("t4_reload", 5'b11000);
        chk("t4_wc0", 32'(word_count), 32'd0);
        tick_back();

        // start pulsed mid-load is ignored
        send("t6w0", W0, 1'b0, 32'h0);
        start = 1'b1;
        send("t6w1", W1, 1'b0, 32'h4);
        start = 1'b0;
        chk("t6_wc", 32'(word_count), 32'd2);
        send("t6w2", W2, 1'b1, 32'h8);
        #4;
        chk_st("t6_done", 5'b00101);
        chk("t6_wc3", 32'(word_count), 32'd3);
        tick();

        // async reset mid-load after two words, valid toggling
        do_start(1'b0);
        wr_base = wr_cnt;
        send("t5w0", W0, 1'b0, 32'h0);
        #4 chk("t5_gap0", 32'(we_b), 32'd0);
        tick_back();
        tick();
        send("t5w1", W1, 1'b0, 32'h4);
        #2 rst = 1'b0;
        #1;
        chk_st("t5_rst_st", 5'b00001);
        chk("t5_rst_wc", 32'(word_count), 32'd0);
        chk("t5_rst_addr", addr_b, 32'd0);
        s_valid = 1'b1;
        s_data  = W2;
        repeat (3) @(posedge clk);
        #1 chk("t5_rst_we", 32'(we_b), 32'd0);
        s_valid = 1'b0;
        #3 rst = 1'b1;
        tick();
        chk("t5_writes", 32'(wr_cnt - wr_base), 32'd2);
        chk_st("t5_idle", 5'b00001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Undo a mid-cycle #4 so the next step starts at posedge+1 again.
    task automatic tick_back();
        #(-0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
